// File: rtl/b06_count_compare.sv
// Run-length counter and registered reference comparator closing the b06 FSM feedback loop.
// Optional ackout rising-edge counter enabled by defining B06_ACK_COUNTER_EN.
module b06_count_compare #(
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_count,
    input  logic              ackout,
    input  logic [1:0]        cc_mux,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] ref_a,
    input  logic [DATA_W-1:0] ref_b,
    input  logic [CNT_W-1:0]  limit,
    output logic              eql,
    output logic              cont_eql,
    output logic              data_ack,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  ack_cnt
);

    localparam logic [1:0] SelNone = 2'b00;
    localparam logic [1:0] SelA    = 2'b01;
    localparam logic [1:0] SelB    = 2'b10;
    localparam logic [1:0] SelXor  = 2'b11;

    // ------------------------------------------------------------------
    // Run-length counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic             cont_eql_q, cont_eql_d;
    logic             en_prev_q, en_prev_d;
    logic             run_start;
    logic [CNT_W-1:0] limit_eff;

    // A run starts on the first enabled cycle; the fresh limit is used immediately.
    assign run_start = enable_count && (count_q == '0) && !en_prev_q;
    assign limit_eff = run_start ? limit : limit_q;

    always_comb begin
        count_d    = count_q;
        limit_d    = limit_q;
        cont_eql_d = cont_eql_q;
        en_prev_d  = enable_count;

        if (run_start) begin
            limit_d = limit;
        end

        if (!enable_count) begin
            count_d    = '0;
            cont_eql_d = 1'b0;
        end else if (count_q == limit_eff) begin
            count_d    = '0;
            cont_eql_d = 1'b1;
        end else begin
            count_d    = count_q + CNT_W'(1);
            cont_eql_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            limit_q    <= '0;
            cont_eql_q <= 1'b0;
            en_prev_q  <= 1'b0;
        end else begin
            count_q    <= count_d;
            limit_q    <= limit_d;
            cont_eql_q <= cont_eql_d;
            en_prev_q  <= en_prev_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered comparator
    // ------------------------------------------------------------------
    logic              eql_q, eql_d;
    logic              data_ack_q, data_ack_d;
    logic [DATA_W-1:0] ref_sel;

    always_comb begin
        ref_sel = '0;
        unique case (cc_mux)
            SelA:    ref_sel = ref_a;
            SelB:    ref_sel = ref_b;
            SelXor:  ref_sel = ref_a ^ ref_b;
            default: ref_sel = '0;
        endcase
    end

    always_comb begin
        eql_d      = eql_q;
        data_ack_d = 1'b0;
        if (data_valid) begin
            eql_d      = (cc_mux != SelNone) && (data_in == ref_sel);
            data_ack_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            eql_q      <= 1'b0;
            data_ack_q <= 1'b0;
        end else begin
            eql_q      <= eql_d;
            data_ack_q <= data_ack_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional ackout rising-edge counter
    // ------------------------------------------------------------------
`ifdef B06_ACK_COUNTER_EN
    logic             ackout_d_q;
    logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;

    always_comb begin
        ack_cnt_d = ack_cnt_q;
        // Saturate at all-ones rather than wrapping.
        if (ackout && !ackout_d_q && (ack_cnt_q != '1)) begin
            ack_cnt_d = ack_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ackout_d_q <= 1'b0;
            ack_cnt_q  <= '0;
        end else begin
            ackout_d_q <= ackout;
            ack_cnt_q  <= ack_cnt_d;
        end
    end

    assign ack_cnt = ack_cnt_q;
`else
    logic unused_ackout;
    assign unused_ackout = ackout;
    assign ack_cnt       = '0;
`endif

    assign count    = count_q;
    assign cont_eql = cont_eql_q;
    assign eql      = eql_q;
    assign data_ack = data_ack_q;

endmodule
